seq_digit_player: RTL and testbench

- Parametrised Mealy sequence stepper for the 7-segment display path.
- Holds a writable table of SEQ_LEN BCD digits and steps an index forward or back on each divided tick. Stepping is driven by a 2-bit command, or by auto-run when the command is idle.
- Drives one active-low 7-segment digit.
- Adds blank mode with restart, a combinational Mealy preview of the next digit, and runtime table loading.

---
 rtl/seq_digit_player_pkg.sv | 32 +++
 rtl/seq_digit_player_bcd_to_seg7.sv | 13 +
 rtl/seq_digit_player.sv | 130 +++++++++++++
 tb/tb_seq_digit_player.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_digit_player_pkg.sv
// Shared encodings and the BCD-to-segment table for the sequence digit player.
// Segment order is {a,b,c,d,e,f,g}, active-low.
package seq_digit_player_pkg;

    typedef enum logic [1:0] {
        CMD_IDLE  = 2'b00,
        CMD_FWD   = 2'b01,
        CMD_BACK  = 2'b10,
        CMD_BLANK = 2'b11
    } cmd_t;

    typedef enum logic {
        ST_SHOW  = 1'b0,
        ST_BLANK = 1'b1
    } state_t;

    localparam logic [6:0] SEG_OFF     = 7'b1111111;
    localparam logic [3:0] DIGIT_BLANK = 4'hF;

    // Codes 10..15 decode to all segments off.
    localparam logic [6:0] SEG_TABLE [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, SEG_OFF,    SEG_OFF,
        SEG_OFF,    SEG_OFF,    SEG_OFF,    SEG_OFF
    };

    function automatic logic [6:0] seg_of(input logic [3:0] bcd);
        return SEG_TABLE[bcd];
    endfunction

endpackage

// File: rtl/seq_digit_player_bcd_to_seg7.sv
// Purely combinational BCD to active-low 7-segment decoder.
module bcd_to_seg7
    import seq_digit_player_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    always_comb begin
        seg = seg_of(bcd);
    end

endmodule

// File: rtl/seq_digit_player.sv
// Table-driven digit sequencer: steps an index through a writable BCD table
// on each divided tick, with a blank state and a Mealy preview of the next digit.
module seq_digit_player
    import seq_digit_player_pkg::*;
#(
    parameter int SEQ_LEN   = 9,
    parameter int DIV_COUNT = 50000000,
    parameter int CNT_W     = 26,
    parameter int IDX_W     = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       cmd,
    input  logic             auto_en,
    input  logic             auto_dir,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_addr,
    input  logic [3:0]       wr_data,
    output logic             tick,
    output logic [IDX_W-1:0] idx,
    output logic [3:0]       digit,
    output logic [3:0]       next_digit,
    output logic             blanked,
    output logic [6:0]       seg
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SEQ_LEN - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV_COUNT - 1);

    logic [CNT_W-1:0] cnt_reg;
    logic             tick_reg;
    state_t           state_reg;
    state_t           state_next;
    logic [IDX_W-1:0] idx_reg;
    logic [IDX_W-1:0] idx_next;
    logic [IDX_W-1:0] idx_inc;
    logic [IDX_W-1:0] idx_dec;
    logic [3:0]       table_word [SEQ_LEN];

    // Tick strobe is registered, so it lands the cycle after the counter wraps.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_reg  <= '0;
            tick_reg <= 1'b0;
        end else if (cnt_reg == CNT_LAST) begin
            cnt_reg  <= '0;
            tick_reg <= 1'b1;
        end else begin
            cnt_reg  <= cnt_reg + 1'b1;
            tick_reg <= 1'b0;
        end
    end

    // One register per table entry; out-of-range addresses match no entry.
    genvar gi;
    generate
        for (gi = 0; gi < SEQ_LEN; gi++) begin : g_entry
            logic [3:0] entry_reg;

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    entry_reg <= 4'(gi % 10);
                end else if (wr_en && (wr_addr == IDX_W'(gi))) begin
                    entry_reg <= wr_data;
                end
            end

            assign table_word[gi] = entry_reg;
        end
    endgenerate

    assign idx_inc = (idx_reg == LAST_IDX) ? '0 : idx_reg + 1'b1;
    assign idx_dec = (idx_reg == '0) ? LAST_IDX : idx_reg - 1'b1;

    // Transition function, shared by the stepping register and the preview.
    always_comb begin
        state_next = state_reg;
        idx_next   = idx_reg;
        case (state_reg)
            ST_SHOW: begin
                case (cmd_t'(cmd))
                    CMD_FWD:   idx_next = idx_inc;
                    CMD_BACK:  idx_next = idx_dec;
                    CMD_BLANK: state_next = ST_BLANK;
                    default: begin
                        if (auto_en) begin
                            idx_next = auto_dir ? idx_dec : idx_inc;
                        end
                    end
                endcase
            end
            ST_BLANK: begin
                if ((cmd_t'(cmd) == CMD_FWD) || (cmd_t'(cmd) == CMD_BACK)) begin
                    state_next = ST_SHOW;
                    idx_next   = '0;
                end
            end
            default: begin
                state_next = ST_SHOW;
                idx_next   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= ST_SHOW;
            idx_reg   <= '0;
        end else if (tick_reg) begin
            state_reg <= state_next;
            idx_reg   <= idx_next;
        end
    end

    always_comb begin
        digit      = (state_reg == ST_BLANK) ? DIGIT_BLANK : table_word[idx_reg];
        next_digit = (state_next == ST_BLANK) ? DIGIT_BLANK : table_word[idx_next];
    end

    assign tick    = tick_reg;
    assign idx     = idx_reg;
    assign blanked = (state_reg == ST_BLANK);

    // Blank digit 4'hF decodes to all-off, so one decoder covers both states.
    bcd_to_seg7 u_seg (
        .bcd (digit),
        .seg (seg)
    );

endmodule

// File: tb/tb_seq_digit_player.sv
// Directed bench for seq_digit_player with DIV_COUNT=4, SEQ_LEN=9.
module tb_seq_digit_player;

    localparam int SEQ_LEN   = 9;
    localparam int DIV_COUNT = 4;
    localparam int CNT_W     = 2;
    localparam int IDX_W     = 4;

    localparam logic [6:0] S0   = 7'b0000001;
    localparam logic [6:0] S3   = 7'b0000110;
    localparam logic [6:0] S5   = 7'b0100100;
    localparam logic [6:0] S7   = 7'b0001111;
    localparam logic [6:0] S8   = 7'b0000000;
    localparam logic [6:0] SOFF = 7'b1111111;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic [1:0]       cmd = 2'b00;
    logic             auto_en = 1'b0;
    logic             auto_dir = 1'b0;
    logic             wr_en = 1'b0;
    logic [IDX_W-1:0] wr_addr = '0;
    logic [3:0]       wr_data = '0;
    logic             tick;
    logic [IDX_W-1:0] idx;
    logic [3:0]       digit;
    logic [3:0]       next_digit;
    logic             blanked;
    logic [6:0]       seg;

    int total = 0;
    int bad   = 0;

    seq_digit_player #(
        .SEQ_LEN   (SEQ_LEN),
        .DIV_COUNT (DIV_COUNT),
        .CNT_W     (CNT_W),
        .IDX_W     (IDX_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .cmd        (cmd),
        .auto_en    (auto_en),
        .auto_dir   (auto_dir),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .tick       (tick),
        .idx        (idx),
        .digit      (digit),
        .next_digit (next_digit),
        .blanked    (blanked),
        .seg        (seg)
    );

    always #5 clk = ~clk;

    // Returns at the falling edge of a tick cycle, before the step is applied.
    task automatic wait_tick(input string name);
        bit found = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (tick === 1'b1) begin
                found = 1;
                break;
            end
        end
        total++;
        if (!found) begin
            bad++;
            $display("FAIL %s tick_timeout: no tick within 8 cycles", name);
        end
    endtask

    task automatic check_step(input string name, input logic [3:0] exp_idx,
                              input logic [3:0] exp_digit);
        total++;
        if (idx !== exp_idx) begin
            bad++;
            $display("FAIL %s idx: got %0d want %0d", name, idx, exp_idx);
        end
        total++;
        if (digit !== exp_digit) begin
            bad++;
            $display("FAIL %s digit: got %h want %h", name, digit, exp_digit);
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        total++;
        if ({tick, idx, digit, blanked, seg} !== {1'b0, 4'd0, 4'd0, 1'b0, S0}) begin
            bad++;
            $display("FAIL reset_state: tick=%b idx=%0d digit=%h blanked=%b seg=%b want 0 0 0 0 %b",
                     tick, idx, digit, blanked, seg, S0);
        end
        reset = 1'b1;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            total++;
            if (tick !== ((n % 4) == 0)) begin
                bad++;
                $display("FAIL idle_tick cycle %0d: got %b want %b", n, tick, (n % 4) == 0);
            end
            total++;
            if ({idx, digit, seg} !== {4'd0, 4'd0, S0}) begin
                bad++;
                $display("FAIL idle_hold cycle %0d: idx=%0d digit=%h seg=%b want 0 0 %b",
                         n, idx, digit, seg, S0);
            end
        end
        @(negedge clk);
        $display("test_reset done total=%0d bad=%0d", total, bad);
    endtask

    task automatic test_forward();
        logic [3:0] exp;
        cmd = 2'b01;
        for (int i = 1; i <= 9; i++) begin
            exp = 4'(i % 9);
            wait_tick("fwd");
            total++;
            if (next_digit !== exp) begin
                bad++;
                $display("FAIL fwd_preview step %0d: got %h want %h", i, next_digit, exp);
            end
            @(negedge clk);
            check_step("fwd", exp, exp);
        end
        $display("test_forward done total=%0d bad=%0d", total, bad);
    endtask

    task automatic test_back_wrap();
        cmd = 2'b10;
        wait_tick("back");
        total++;
        if (next_digit !== 4'd8) begin
            bad++;
            $display("FAIL back_preview: got %h want 8", next_digit);
        end
        @(negedge clk);
        check_step("back", 4'd8, 4'd8);
        total++;
        if (seg !== S8) begin
            bad++;
            $display("FAIL back_seg: got %b want %b", seg, S8);
        end
        $display("test_back_wrap done total=%0d bad=%0d", total, bad);
    endtask

    task automatic test_blank();
        cmd = 2'b11;
        wait_tick("blank_in");
        total++;
        if (next_digit !== 4'hF) begin
            bad++;
            $display("FAIL blank_preview: got %h want f", next_digit);
        end
        @(negedge clk);
        total++;
        if ({blanked, seg, digit, idx} !== {1'b1, SOFF, 4'hF, 4'd8}) begin
            bad++;
            $display("FAIL blank_enter: blanked=%b seg=%b digit=%h idx=%0d want 1 %b f 8",
                     blanked, seg, digit, idx, SOFF);
        end
        cmd = 2'b00;
        auto_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            wait_tick("blank_hold");
            total++;
            if (next_digit !== 4'hF) begin
                bad++;
                $display("FAIL blank_hold_preview %0d: got %h want f", i, next_digit);
            end
            @(negedge clk);
            total++;
            if ({blanked, seg, digit} !== {1'b1, SOFF, 4'hF}) begin
                bad++;
                $display("FAIL blank_hold %0d: blanked=%b seg=%b digit=%h", i, blanked, seg, digit);
            end
        end
        auto_en = 1'b0;
        cmd = 2'b10;
        wait_tick("blank_out");
        total++;
        if (next_digit !== 4'd0) begin
            bad++;
            $display("FAIL blank_exit_preview: got %h want 0", next_digit);
        end
        @(negedge clk);
        check_step("blank_exit", 4'd0, 4'd0);
        total++;
        if (blanked !== 1'b0) begin
            bad++;
            $display("FAIL blank_exit_flag: got %b want 0", blanked);
        end
        cmd = 2'b00;
        $display("test_blank done total=%0d bad=%0d", total, bad);
    endtask

    task automatic test_table_write();
        logic [3:0] exp_d [3];
        exp_d[0] = 4'd1;
        exp_d[1] = 4'd2;
        exp_d[2] = 4'd7;
        wr_en = 1'b1; wr_addr = 4'd3; wr_data = 4'd7;
        @(negedge clk);
        wr_addr = 4'd9; wr_data = 4'd12;
        @(negedge clk);
        wr_en = 1'b0;
        check_step("wr_ignored", 4'd0, 4'd0);
        cmd = 2'b01;
        for (int i = 0; i < 3; i++) begin
            wait_tick("wr_step");
            total++;
            if (next_digit !== exp_d[i]) begin
                bad++;
                $display("FAIL wr_preview %0d: got %h want %h", i, next_digit, exp_d[i]);
            end
            @(negedge clk);
            check_step("wr_step", 4'(i + 1), exp_d[i]);
        end
        cmd = 2'b00;
        total++;
        if (seg !== S7) begin
            bad++;
            $display("FAIL wr_seg7: got %b want %b", seg, S7);
        end
        wr_en = 1'b1; wr_addr = 4'd3; wr_data = 4'd5;
        @(negedge clk);
        wr_en = 1'b0;
        total++;
        if ({digit, seg} !== {4'd5, S5}) begin
            bad++;
            $display("FAIL wr_live: digit=%h seg=%b want 5 %b", digit, seg, S5);
        end
        wr_en = 1'b1; wr_data = 4'd12;
        @(negedge clk);
        wr_en = 1'b0;
        total++;
        if ({digit, seg} !== {4'hC, SOFF}) begin
            bad++;
            $display("FAIL wr_nonbcd: digit=%h seg=%b want c %b", digit, seg, SOFF);
        end
        $display("test_table_write done total=%0d bad=%0d", total, bad);
    endtask

    task automatic test_back_to_back();
        cmd = 2'b10;
        wait_tick("b2b_back");
        total++;
        if (next_digit !== 4'd2) begin
            bad++;
            $display("FAIL b2b_preview_back: got %h want 2", next_digit);
        end
        wr_en = 1'b1; wr_addr = 4'd3; wr_data = 4'd9;
        @(negedge clk);
        wr_en = 1'b0;
        check_step("b2b_back", 4'd2, 4'd2);
        cmd = 2'b01;
        wait_tick("b2b_fwd");
        total++;
        if (next_digit !== 4'd9) begin
            bad++;
            $display("FAIL b2b_preview_fwd: got %h want 9", next_digit);
        end
        @(negedge clk);
        check_step("b2b_fwd", 4'd3, 4'd9);
        cmd = 2'b00;
        $display("test_back_to_back done total=%0d bad=%0d", total, bad);
    endtask

    task automatic test_auto_reset();
        logic [3:0] exp_seq [7];
        int wait_n;
        exp_seq = '{4'd2, 4'd1, 4'd0, 4'd8, 4'd7, 4'd6, 4'd5};
        auto_en = 1'b1; auto_dir = 1'b1; cmd = 2'b00;
        for (int i = 0; i < 7; i++) begin
            wait_tick("auto");
            total++;
            if (next_digit !== exp_seq[i]) begin
                bad++;
                $display("FAIL auto_preview %0d: got %h want %h", i, next_digit, exp_seq[i]);
            end
            @(negedge clk);
            check_step("auto", exp_seq[i], exp_seq[i]);
        end
        @(negedge clk);
        reset = 1'b0;
        #1;
        total++;
        if ({tick, idx, digit, blanked, seg} !== {1'b0, 4'd0, 4'd0, 1'b0, S0}) begin
            bad++;
            $display("FAIL async_reset: tick=%b idx=%0d digit=%h blanked=%b seg=%b",
                     tick, idx, digit, blanked, seg);
        end
        auto_en = 1'b0; auto_dir = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        wait_n = 0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (tick === 1'b1) begin
                wait_n = k;
                break;
            end
        end
        total++;
        if (wait_n != 4) begin
            bad++;
            $display("FAIL reset_restart: first tick after %0d cycles want 4", wait_n);
        end
        @(negedge clk);
        cmd = 2'b01;
        for (int i = 1; i <= 3; i++) begin
            wait_tick("post_reset");
            @(negedge clk);
        end
        cmd = 2'b00;
        check_step("table_restored", 4'd3, 4'd3);
        total++;
        if (seg !== S3) begin
            bad++;
            $display("FAIL table_restored_seg: got %b want %b", seg, S3);
        end
        $display("test_auto_reset done total=%0d bad=%0d", total, bad);
    endtask

    initial begin
        test_reset();
        test_forward();
        test_back_wrap();
        test_blank();
        test_table_write();
        test_back_to_back();
        test_auto_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
